// File: rtl/mac_sched.sv
// mac_sched: round-robin scheduler feeding BURST operand pairs from one of two requesters into a mac
//   req0/req1, in_a*/in_b*  : requests and signed 4-bit operands per requester
//   gnt0/gnt1               : registered grant, operand pair sampled on each gnt-high edge
//   mac_a/mac_b/mac_valid   : operands to the mac, one cycle behind gnt, zero when not valid
//   mac_out/mac_out_valid   : accumulated result from the mac, only honoured in WAIT
//   res_data/res_valid0/1   : captured result and one-cycle strobe to the owner
//   err                     : one-cycle strobe when the mac result does not arrive within TMO cycles
//   busy                    : high whenever the scheduler is not idle
module mac_sched #(
  parameter int BURST = 8,
  parameter int TMO = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0,
  input  logic               req1,
  input  logic signed [3:0]  in_a0,
  input  logic signed [3:0]  in_b0,
  input  logic signed [3:0]  in_a1,
  input  logic signed [3:0]  in_b1,
  output logic               gnt0,
  output logic               gnt1,
  output logic signed [3:0]  mac_a,
  output logic signed [3:0]  mac_b,
  output logic               mac_valid,
  input  logic signed [10:0] mac_out,
  input  logic               mac_out_valid,
  output logic signed [10:0] res_data,
  output logic               res_valid0,
  output logic               res_valid1,
  output logic               err,
  output logic               busy
);
  typedef enum logic [2:0] {IDLE, FEED, DRAIN, WAIT, RESP} state_t;
  state_t state, next;
  logic [2:0] fcnt;
  logic [3:0] wcnt;
  logic last, own, pick, nown, timeout;
  always_comb begin
    pick = (req0 & req1) ? ~last : req1;
    nown = (state == IDLE) ? pick : own;
    timeout = (state == WAIT) && !mac_out_valid && (wcnt == 4'(TMO - 1));
    next = state;
    case (state)
      IDLE:  next = (req0 | req1) ? FEED : IDLE;
      FEED:  next = (fcnt == 3'(BURST - 1)) ? DRAIN : FEED;
      DRAIN: next = WAIT;
      WAIT:  next = mac_out_valid ? RESP : timeout ? IDLE : WAIT;
      RESP:  next = IDLE;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      fcnt <= '0;
      wcnt <= '0;
      last <= 1'b1;
      own <= 1'b0;
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      mac_a <= '0;
      mac_b <= '0;
      mac_valid <= 1'b0;
      res_data <= '0;
      res_valid0 <= 1'b0;
      res_valid1 <= 1'b0;
      err <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= next;
      fcnt <= (state == FEED && next == FEED) ? fcnt + 3'd1 : 3'd0;
      wcnt <= (state == WAIT) ? wcnt + 4'd1 : 4'd0;
      if (state == IDLE && next == FEED) begin
        own <= pick;
        last <= pick;
      end
      gnt0 <= (next == FEED) && !nown;
      gnt1 <= (next == FEED) && nown;
      mac_valid <= gnt0 | gnt1;
      mac_a <= gnt0 ? in_a0 : gnt1 ? in_a1 : 4'sd0;
      mac_b <= gnt0 ? in_b0 : gnt1 ? in_b1 : 4'sd0;
      if (state == WAIT && mac_out_valid) res_data <= mac_out;
      res_valid0 <= (next == RESP) && !own;
      res_valid1 <= (next == RESP) && own;
      err <= timeout;
      busy <= next != IDLE;
    end
  end
endmodule

// File: tb/tb_mac_sched.sv
// tb_mac_sched: directed bench for mac_sched with a behavioural 8-pair mac model
module tb_mac_sched;
  logic clk = 1'b0, reset = 1'b1, req0 = 1'b0, req1 = 1'b0;
  logic signed [3:0] in_a0 = '0, in_b0 = '0, in_a1 = '0, in_b1 = '0;
  logic gnt0, gnt1, mac_valid, res_valid0, res_valid1, err, busy;
  logic signed [3:0] mac_a, mac_b;
  logic signed [10:0] mac_out, res_data;
  logic mac_out_valid, mo_v = 1'b0, mac_en = 1'b1, force_ov = 1'b0;
  int acc = 0, mo = 0, n_in = 0;
  int tests = 0, fails = 0;
  int cyc = 0, g0c = 0, g1c = 0, mvc = 0, mv_runs = 0, errc = 0, ovl = 0, gap_err = 0;
  int mv_fall = 0, err_cyc = 0;
  logic prev_g = 1'b0, prev_mv = 1'b0, prev_busy = 1'b0;
  int q_g[$], q_r[$], q_d[$];
  logic [24:0] outs;
  mac_sched dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1),
    .in_a0(in_a0), .in_b0(in_b0), .in_a1(in_a1), .in_b1(in_b1),
    .gnt0(gnt0), .gnt1(gnt1), .mac_a(mac_a), .mac_b(mac_b), .mac_valid(mac_valid),
    .mac_out(mac_out), .mac_out_valid(mac_out_valid), .res_data(res_data),
    .res_valid0(res_valid0), .res_valid1(res_valid1), .err(err), .busy(busy)
  );
  always #5 clk = ~clk;
  assign outs = {gnt0, gnt1, mac_a, mac_b, mac_valid, res_data, res_valid0, res_valid1, err, busy};
  assign mac_out = 11'(mo);
  assign mac_out_valid = mo_v | force_ov;
  always @(posedge clk) begin
    if (reset) begin
      acc <= 0;
      n_in <= 0;
      mo_v <= 1'b0;
    end else begin
      mo_v <= 1'b0;
      if (mac_valid) begin
        if (n_in == 7) begin
          mo <= acc + int'(mac_a) * int'(mac_b);
          mo_v <= mac_en;
          acc <= 0;
          n_in <= 0;
        end else begin
          acc <= acc + int'(mac_a) * int'(mac_b);
          n_in <= n_in + 1;
        end
      end
    end
  end
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (gnt0) g0c <= g0c + 1;
    if (gnt1) g1c <= g1c + 1;
    if (mac_valid) mvc <= mvc + 1;
    if (mac_valid && !prev_mv) mv_runs <= mv_runs + 1;
    if (!mac_valid && prev_mv) mv_fall <= cyc;
    if ((gnt0 | gnt1) && !prev_g) begin
      q_g.push_back(gnt1 ? 1 : 0);
      if (prev_busy) gap_err <= gap_err + 1;
    end
    if (err) begin
      errc <= errc + 1;
      err_cyc <= cyc;
    end
    if (res_valid0 | res_valid1) begin
      q_r.push_back(res_valid1 ? 1 : 0);
      q_d.push_back(int'(res_data));
    end
    if ((gnt0 & gnt1) | (res_valid0 & res_valid1)) ovl <= ovl + 1;
    prev_g <= gnt0 | gnt1;
    prev_mv <= mac_valid;
    prev_busy <= busy;
  end
  task automatic chk(input string tag, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_res(input string tag, input int n);
    for (int i = 0; i < 200 && q_r.size() < n; i++) tick();
    chk(tag, q_r.size(), n);
  endtask
  task automatic wait_gnt(input string tag, input int n);
    for (int i = 0; i < 200 && q_g.size() < n; i++) tick();
    chk(tag, q_g.size(), n);
  endtask
  task automatic settle();
    repeat (3) tick();
  endtask
  initial begin
    int n, ng, b0, b1, bm, br, be, bo, bgap;
    repeat (3) tick();
    chk("rst_outs", int'(outs), 0);
    reset = 1'b0;
    tick();
    chk("idle_busy", busy, 0);
    // single requester, (3,2) x 8 = 48
    in_a0 = 4'sd3; in_b0 = 4'sd2;
    n = q_r.size(); b0 = g0c; bm = mvc; br = mv_runs;
    req0 = 1'b1;
    tick();
    req0 = 1'b0;
    chk("s1_gnt0", gnt0, 1);
    chk("s1_gnt1", gnt1, 0);
    chk("s1_busy", busy, 1);
    tick();
    chk("s1_mac_a", int'(mac_a), 3);
    chk("s1_mac_valid", mac_valid, 1);
    wait_res("s1_wait", n + 1);
    settle();
    chk("s1_gnt_cycles", g0c - b0, 8);
    chk("s1_mv_cycles", mvc - bm, 8);
    chk("s1_mv_runs", mv_runs - br, 1);
    chk("s1_owner", q_r[n], 0);
    chk("s1_data", q_d[n], 48);
    chk("s1_busy_after", busy, 0);
    chk("s1_mac_a_idle", int'(mac_a), 0);
    // tie right after reset: requester 0 first, then 1
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    in_a0 = -4'sd8; in_b0 = -4'sd8; in_a1 = -4'sd8; in_b1 = 4'sd7;
    req0 = 1'b1; req1 = 1'b1;
    n = q_r.size(); ng = q_g.size(); bo = ovl; b1 = g1c;
    wait_gnt("s2_wait_gnt", ng + 2);
    req0 = 1'b0; req1 = 1'b0;
    wait_res("s2_wait", n + 2);
    settle();
    chk("s2_g_first", q_g[ng], 0);
    chk("s2_g_second", q_g[ng + 1], 1);
    chk("s2_r0_owner", q_r[n], 0);
    chk("s2_r0_data", q_d[n], 512);
    chk("s2_r1_owner", q_r[n + 1], 1);
    chk("s2_r1_data", q_d[n + 1], -448);
    chk("s2_gnt1_cycles", g1c - b1, 8);
    chk("s2_overlap", ovl - bo, 0);
    // continuous requests alternate with an idle gap between groups
    in_a0 = 4'sd1; in_b0 = 4'sd1; in_a1 = 4'sd2; in_b1 = 4'sd1;
    n = q_r.size(); ng = q_g.size(); br = mv_runs; bm = mvc; bgap = gap_err; bo = ovl;
    req0 = 1'b1; req1 = 1'b1;
    wait_gnt("s3_wait_gnt", ng + 4);
    req0 = 1'b0; req1 = 1'b0;
    wait_res("s3_wait", n + 4);
    settle();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("s3_grant%0d", i), q_g[ng + i], i % 2);
      chk($sformatf("s3_owner%0d", i), q_r[n + i], q_g[ng + i]);
      chk($sformatf("s3_data%0d", i), q_d[n + i], (i % 2 == 1) ? 16 : 8);
    end
    chk("s3_gap", gap_err - bgap, 0);
    chk("s3_mv_runs", mv_runs - br, 4);
    chk("s3_mv_cycles", mvc - bm, 32);
    chk("s3_overlap", ovl - bo, 0);
    // missing mac result: timeout after TMO wait cycles
    mac_en = 1'b0;
    in_a0 = 4'sd3; in_b0 = 4'sd2;
    n = q_r.size(); be = errc;
    req0 = 1'b1;
    tick();
    req0 = 1'b0;
    for (int i = 0; i < 200 && errc == be; i++) tick();
    chk("s4_busy_at_err", busy, 0);
    repeat (20) tick();
    chk("s4_err_count", errc - be, 1);
    chk("s4_err_delay", err_cyc - mv_fall, 15);
    chk("s4_no_res", q_r.size() - n, 0);
    mac_en = 1'b1;
    // next request accepted; req1 dropped during FEED still yields a full burst
    in_a1 = 4'sd2; in_b1 = -4'sd3;
    b1 = g1c; be = errc;
    req1 = 1'b1;
    tick();
    tick();
    req1 = 1'b0;
    wait_res("s6_wait", n + 1);
    settle();
    chk("s6_gnt1_cycles", g1c - b1, 8);
    chk("s6_owner", q_r[n], 1);
    chk("s6_data", q_d[n], -48);
    // stray mac_out_valid during IDLE is ignored
    force_ov = 1'b1;
    tick();
    force_ov = 1'b0;
    repeat (5) tick();
    chk("s6_stray_res", q_r.size() - n, 1);
    chk("s6_stray_busy", busy, 0);
    chk("s6_stray_data", int'(res_data), -48);
    // reset on the 4th FEED cycle of a req1 group
    in_a1 = 4'sd5; in_b1 = 4'sd5;
    n = q_r.size(); be = errc;
    req1 = 1'b1;
    tick();
    req1 = 1'b0;
    chk("s5_gnt1", gnt1, 1);
    repeat (3) tick();
    chk("s5_still_feed", gnt1, 1);
    reset = 1'b1;
    tick();
    chk("s5_rst_outs", int'(outs), 0);
    reset = 1'b0;
    in_a0 = 4'sd1; in_b0 = 4'sd1;
    req0 = 1'b1;
    tick();
    req0 = 1'b0;
    wait_res("s5_wait", n + 1);
    settle();
    chk("s5_owner", q_r[n], 0);
    chk("s5_data", q_d[n], 8);
    chk("s5_no_err", errc - be, 0);
    chk("s5_overlap", ovl - bo, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mac_sched.md
MAC_SCHED -- requirements
Module: mac_sched

Interface
REQ-001 SHALL have one clock `clk`; reset `reset` is synchronous and active-high.
REQ-002 Parameter: BURST, default 8, operand pairs per accumulation group. This value matches the fixed group length of the mac datapath.
REQ-003 Parameter: TMO, default 15, maximum WAIT cycles before a timeout is declared.
REQ-004 Ports, one per line:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- req0, req1  in  1 each  requester wants one group
- in_a0, in_b0  in  4 each  signed operands, requester 0
- in_a1, in_b1  in  4 each  signed operands, requester 1
- gnt0, gnt1  out  1 each  registered; high means the operand pair is sampled at this edge
- mac_a, mac_b  out  4 each  signed operands to mac
- mac_valid  out  1  drives both mac in_valid_a and in_valid_b
- mac_out  in  11  signed accumulated result from mac
- mac_out_valid  in  1  mac result strobe
- res_data  out  11  signed result returned to the owner
- res_valid0, res_valid1  out  1 each  one-cycle result strobe per requester
- err  out  1  one-cycle timeout strobe
- busy  out  1  high in any state other than IDLE

Function
REQ-005 FSM states: IDLE, FEED, DRAIN, WAIT, RESP.
REQ-006 IDLE: if req0 or req1 is high, the FSM SHALL pick an owner, assert that owner's gnt on the next cycle and go to FEED. Otherwise it stays in IDLE.
REQ-007 Arbitration SHALL be round-robin; on simultaneous requests the requester not served last wins. After reset, requester 0 wins a tie.
REQ-008 FEED SHALL last exactly BURST cycles with the owner's gnt high. A 3-bit counter counts 0..BURST-1; at count BURST-1 the FSM goes to DRAIN.
REQ-009 On each gnt-high edge, the owner's in_a/in_b SHALL be registered into mac_a/mac_b, and mac_valid SHALL be high in the following cycle. mac_valid is therefore high for exactly BURST contiguous cycles, delayed one cycle from gnt.
REQ-010 DRAIN SHALL last 1 cycle, covering the final mac_valid cycle, then go to WAIT.
REQ-011 When mac_valid is low, mac_a and mac_b SHALL be 0.
REQ-012 The non-owner's gnt SHALL stay 0. Deasserting req during FEED SHALL NOT shorten the burst.
REQ-013 WAIT: on mac_out_valid, mac_out SHALL be registered into res_data and the FSM goes to RESP.
- A 4-bit counter starts at 0 on WAIT entry.
- If the counter reaches TMO without mac_out_valid, err SHALL pulse for 1 cycle, no res_valid is issued, and the FSM goes to IDLE.
REQ-014 RESP: the owner's res_valid SHALL be high for exactly 1 cycle, then the FSM goes to IDLE. res_data SHALL hold its value until the next capture.
REQ-015 IDLE SHALL last at least 1 cycle between groups, giving the mac a one-cycle mac_valid-low gap.
REQ-016 mac_out_valid outside WAIT SHALL be ignored.
REQ-017 The round-robin pointer SHALL update only when a grant is issued.
REQ-018 res_valid0, res_valid1, gnt0 and gnt1 SHALL never be high simultaneously; at most one of each pair is high in any cycle.

Reset
REQ-019 While reset is high, the FSM SHALL go to IDLE and all counters SHALL clear.
REQ-020 While reset is high, all outputs SHALL be 0, and the round-robin pointer SHALL be set so requester 0 wins the next tie.
REQ-021 Reset asserted mid-FEED, DRAIN or WAIT SHALL abort the group at the next edge with no res_valid and no err. mac_valid SHALL drop in the same cycle, giving the mac its own synchronous reset window.

Verification
REQ-022 The bench SHALL instantiate mac_sched driving a mac instance and SHALL cover:
- req0 only, all 8 pairs (3,2) -> gnt0 high 8 cycles; mac_valid high 8 contiguous cycles; res_valid0 pulse with res_data=48; busy low afterwards.
- req0 and req1 both high from the first cycle after reset; req0 pairs (-8,-8), req1 pairs (-8,7) -> group 0 first with res_data=512 on res_valid0, then group 1 with res_data=-448 on res_valid1; no gnt overlap.
- Both requests held high continuously -> grants alternate 0,1,0,1; at least 1 IDLE cycle between groups; res_valid owner matches each grant.
- mac_out_valid tied low -> err pulses exactly once, TMO cycles after WAIT entry; no res_valid; FSM returns to IDLE and accepts the next req.
- Reset pulsed on the 4th FEED cycle of a req1 group -> next cycle all outputs are 0; then a req0 group of (1,1) yields res_data=8.
- req1 deasserted during FEED -> burst still completes 8 pairs; mac_out_valid pulsed during IDLE is ignored (no res_valid).
